// File: rtl/mem_arb_pkg.sv
// Shared opcodes, bus direction encodings and FSM state type for the memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam logic [3:0] OP_LDR   = 4'b1101;
  localparam logic [3:0] OP_STR   = 4'b1110;
  localparam logic       RW_READ  = 1'b1;
  localparam logic       RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Only loads and stores ever reach the memory.
  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant pick between instruction fetch and data port with anti-starvation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only acts on the grant while idle.
// Ports: if_req/d_req requests, starve_cnt data grants given while fetch waited,
//        grant_d/grant_f one-hot (or both low) grant.
module mem_arb_select #(
  parameter int STARVE_MAX = 3,
  parameter int SW         = 2
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          grant_d,
  output logic          grant_f
);

  logic starved;

  // Data wins ties until fetch has been passed over STARVE_MAX times in a row.
  assign starved = if_req && (starve_cnt == SW'(STARVE_MAX));
  assign grant_d = d_req && !starved;
  assign grant_f = if_req && !grant_d;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access (IDLE->ACCESS->DONE).
// Latency: grant at cycle 0, mem_en cycles 1..MEM_LAT, ack at MEM_LAT+1; illegal op acks at cycle 1.
// Backpressure: requesters hold req/operands until ack; requests are sampled only in IDLE.
// Ports: if_* fetch port, d_* data port, mem_* memory side; clk, rst (sync, active-high).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_op,
  input  logic [15:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int          SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [3:0]  LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  state_t        state, state_nxt;
  logic [3:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          own_d;     // current access belongs to the data port
  logic          own_ldr;   // current data access is a load
  logic          grant_d, grant_f;
  logic          d_legal;

  assign d_legal = op_legal(d_op);

  mem_arb_select #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_select (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .grant_d    (grant_d),
    .grant_f    (grant_f)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // Illegal data ops skip the memory entirely and go straight to the ack.
        if (grant_d && !d_legal)    state_nxt = ST_DONE;
        else if (grant_d || grant_f) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: if (lat_cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // All outputs are registered; they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt    <= '0;
      starve_cnt <= '0;
      own_d      <= 1'b0;
      own_ldr    <= 1'b0;
      mem_en     <= 1'b0;
      mem_rw     <= RW_READ;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_f) begin
            own_d      <= 1'b0;
            own_ldr    <= 1'b0;
            starve_cnt <= '0;
            mem_en     <= 1'b1;
            mem_rw     <= RW_READ;
            mem_addr   <= {8'h00, if_addr};
            lat_cnt    <= LAT_LOAD;
          end else if (grant_d) begin
            own_d   <= 1'b1;
            own_ldr <= (d_op == OP_LDR);
            // Count only grants that actually made a waiting fetch wait longer.
            if (if_req && (starve_cnt != STARVE_TOP)) starve_cnt <= starve_cnt + 1'b1;
            if (d_legal) begin
              mem_en   <= 1'b1;
              mem_rw   <= (d_op == OP_STR) ? RW_WRITE : RW_READ;
              mem_addr <= d_addr;
              if (d_op == OP_STR) mem_wdata <= d_wdata;
              lat_cnt  <= LAT_LOAD;
            end else begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (lat_cnt == '0) begin
            mem_en <= 1'b0;
            mem_rw <= RW_READ;
            if (own_d) begin
              d_ack <= 1'b1;
              if (own_ldr) d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          d_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int L    = 2;
  localparam int SMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic [3:0]  d_op;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        b_d_req;
  logic        b_if_ack, b_d_ack, b_d_err, b_mem_en, b_mem_rw;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata;
  logic [15:0] b_mem_addr;

  mem_bus_arbiter #(.MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Second instance with single-cycle memory for back-to-back load timing.
  mem_bus_arbiter #(.MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(8'h00), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_op(OP_LDR), .d_addr(16'h0100), .d_wdata(32'h0),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .d_err(b_d_err),
    .mem_en(b_mem_en), .mem_rw(b_mem_rw), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(32'h0BADF00D)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Transaction-level reference: one record for the last grant, plus timeline arithmetic.
  int          g = -1000;       // cycle in which the last grant was taken
  bit          t_fetch = 1'b0;
  bit          t_legal = 1'b0;
  bit          t_str = 1'b0;
  logic [15:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  int          free_at = 0;     // first cycle in which a new request can be granted
  int          starve = 0;
  logic [31:0] e_ifr = '0, e_dr = '0;
  bit          rst_seen = 1'b0;
  bit          m_if_ack = 1'b0, m_d_ack = 1'b0;

  bit          rec_on = 1'b0;
  int          nrec = 0;
  logic [7:0]  order = '0;      // bit i set = i-th grant went to fetch

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Consume the inputs present during cycle cyc.
  task automatic model_sample();
    bit pick_d;
    if (rst) begin
      g = -1000; t_legal = 1'b0; t_fetch = 1'b0; t_str = 1'b0;
      starve = 0; e_ifr = '0; e_dr = '0;
      free_at = cyc + 1;
      rst_seen = 1'b1;
      return;
    end
    rst_seen = 1'b0;
    if (t_legal && !t_str && cyc == g + L) begin
      if (t_fetch) e_ifr = mem_rdata;
      else         e_dr  = mem_rdata;
    end
    if (cyc >= free_at && (if_req || d_req)) begin
      pick_d  = d_req && !(if_req && starve == SMAX);
      g       = cyc;
      t_fetch = !pick_d;
      if (pick_d) begin
        t_legal = (d_op == OP_LDR) || (d_op == OP_STR);
        t_str   = (d_op == OP_STR);
        t_addr  = d_addr;
        t_wdata = d_wdata;
        if (if_req && starve < SMAX) starve++;
      end else begin
        t_legal = 1'b1;
        t_str   = 1'b0;
        t_addr  = {8'h00, if_addr};
        starve  = 0;
      end
      free_at = t_legal ? cyc + L + 2 : cyc + 2;
    end
  endtask

  // Compare DUT outputs of cycle cyc against the reference timeline.
  task automatic check_all();
    int ackc;
    bit en;
    ackc = t_legal ? g + L + 1 : g + 1;
    en   = t_legal && (cyc > g) && (cyc <= g + L);
    m_if_ack = (cyc == ackc) && t_fetch;
    m_d_ack  = (cyc == ackc) && !t_fetch;
    chk("mem_en", mem_en, en);
    chk("mem_rw", mem_rw, en ? !t_str : 1'b1);
    if (en) chk("mem_addr", mem_addr, t_addr);
    if (en && t_str) chk("mem_wdata", mem_wdata, t_wdata);
    if (rst_seen) begin
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
    end
    chk("if_ack", if_ack, m_if_ack);
    chk("d_ack", d_ack, m_d_ack);
    chk("d_err", d_err, m_d_ack && !t_legal);
    chk("if_rdata", if_rdata, e_ifr);
    chk("d_rdata", d_rdata, e_dr);
    if (rec_on && (if_ack || d_ack)) begin
      if (nrec < 8) order[nrec] = if_ack;
      nrec++;
    end
  endtask

  task automatic tick();
    model_sample();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  // Requesters: drop at ack, then start a new request with the given probability.
  task automatic drive_rand(input int fp, input int dp);
    int r;
    if (m_if_ack) if_req = 1'b0;
    if (m_d_ack)  d_req  = 1'b0;
    if (!if_req && $urandom_range(99) < fp) begin
      if_req  = 1'b1;
      if_addr = 8'($urandom);
    end
    if (!d_req && $urandom_range(99) < dp) begin
      r = $urandom_range(9);
      d_req   = 1'b1;
      d_op    = (r < 4) ? OP_LDR : (r < 8) ? OP_STR : 4'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = $urandom;
    end
    mem_rdata = $urandom;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_op = '0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; b_d_req = 1'b0;
    tick(); tick();
    chk("rst_mem_en", mem_en, 32'h0);
    chk("rst_mem_rw", mem_rw, 32'h1);
    rst = 1'b0;

    // Fetch at 0x3C with a fixed memory word.
    if_req = 1'b1; if_addr = 8'h3C; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("f_en1", mem_en, 32'h1); chk("f_addr", mem_addr, 32'h003C); chk("f_rw", mem_rw, 32'h1);
    tick();
    chk("f_en2", mem_en, 32'h1); chk("f_addr2", mem_addr, 32'h003C);
    tick();
    chk("f_ack", if_ack, 32'h1); chk("f_en_off", mem_en, 32'h0);
    chk("f_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    tick();

    // Load, then a store that must leave d_rdata alone.
    d_req = 1'b1; d_op = OP_LDR; d_addr = 16'h0042; mem_rdata = 32'h12345678;
    tick(); tick(); tick();
    chk("ldr_ack", d_ack, 32'h1); chk("ldr_rdata", d_rdata, 32'h12345678);
    d_op = OP_STR; d_addr = 16'h1234; d_wdata = 32'hA5A5A5A5; mem_rdata = 32'hFFFF0000;
    tick(); tick();
    chk("str_rw1", mem_rw, 32'h0); chk("str_addr1", mem_addr, 32'h1234);
    chk("str_wd1", mem_wdata, 32'hA5A5A5A5);
    tick();
    chk("str_rw2", mem_rw, 32'h0); chk("str_addr2", mem_addr, 32'h1234);
    chk("str_wd2", mem_wdata, 32'hA5A5A5A5);
    tick();
    chk("str_ack", d_ack, 32'h1); chk("str_rw_off", mem_rw, 32'h1);
    chk("str_rdata", d_rdata, 32'h12345678);

    // Illegal opcode: ack+err one cycle after grant, no memory cycle.
    d_op = 4'b0011;
    tick(); tick();
    chk("ill_ack", d_ack, 32'h1); chk("ill_err", d_err, 32'h1); chk("ill_en", mem_en, 32'h0);
    d_req = 1'b0;
    tick();

    // Reset in the first access cycle of a load.
    d_req = 1'b1; d_op = OP_LDR; d_addr = 16'h0777; mem_rdata = 32'h11112222;
    tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    chk("mr_dack", d_ack, 32'h0); chk("mr_en", mem_en, 32'h0); chk("mr_rw", mem_rw, 32'h1);
    chk("mr_drdata", d_rdata, 32'h0); chk("mr_ifrdata", if_rdata, 32'h0);
    rst = 1'b0; if_req = 1'b1; if_addr = 8'h55; mem_rdata = 32'hCAFEF00D;
    tick(); tick(); tick();
    chk("mr_fack", if_ack, 32'h1); chk("mr_frdata", if_rdata, 32'hCAFEF00D);
    if_req = 1'b0;
    tick();

    // Both ports requesting continuously: fetch gets every fourth grant.
    rec_on = 1'b1; nrec = 0; m_if_ack = 1'b0; m_d_ack = 1'b0;
    for (int i = 0; i < 100 && nrec < 8; i++) begin
      drive_rand(100, 100);
      tick();
    end
    rec_on = 1'b0;
    chk("grant_order", order, 32'h88);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_rand(30, 40);
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // MEM_LAT=1 back-to-back loads: one mem_en cycle each, ack every 3 cycles.
    b_d_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("b_en", b_mem_en, (k % 3) == 1);
      chk("b_ack", b_d_ack, (k % 3) == 2);
      if (k == 2) chk("b_rdata", b_d_rdata, 32'h0BADF00D);
    end
    b_d_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles from first mem_en cycle to valid mem_rdata; legal range 1..15.
REQ-002 SHALL have parameter STARVE_MAX, default 3: maximum consecutive data grants while fetch waits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request.
REQ-006 if_addr  input  8  fetch address (pc).
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetched word, valid with if_ack.
REQ-009 d_req  input  1  data-access request.
REQ-010 d_op  input  4  opcode; 4'b1101 LDR, 4'b1110 STR.
REQ-011 d_addr  input  16  data address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 d_rdata  output  32  load data, valid with d_ack on LDR.
REQ-015 d_err  output  1  illegal opcode flag, valid with d_ack.
REQ-016 mem_en  output  1  memory access strobe.
REQ-017 mem_rw  output  1  1 = read, 0 = write.
REQ-018 mem_addr  output  16  memory address.
REQ-019 mem_wdata  output  32  memory write data.
REQ-020 mem_rdata  input  32  memory read data.

Function
REQ-021 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; all outputs registered.
REQ-022 IDLE: no request -> stay; request present -> latch winner's address, op and data, then go to ACCESS (or to DONE per REQ-028).
REQ-023 Arbitration: only d_req -> data; only if_req -> fetch; both -> data, unless starve count == STARVE_MAX, then fetch.
REQ-024 Starve count: +1 on each data grant while if_req high; cleared on fetch grant; saturates at STARVE_MAX.
REQ-025 ACCESS: mem_en=1 for exactly MEM_LAT cycles. mem_addr, mem_rw and mem_wdata stay constant throughout.
REQ-026 Fetch access: mem_addr={8'h00,if_addr}, mem_rw=1. LDR: mem_addr=d_addr, mem_rw=1. STR: mem_addr=d_addr, mem_rw=0, mem_wdata=d_wdata.
REQ-027 Latency counter loads MEM_LAT-1 on entering ACCESS. At 0, capture mem_rdata (reads only) and go to DONE.
REQ-028 Data request with illegal d_op: no memory cycle; IDLE -> DONE directly; d_ack=1 and d_err=1 in DONE.
REQ-029 DONE: pulse the winner's ack for exactly one cycle with rdata valid, then IDLE. For a legal request granted at cycle 0, ack occurs at cycle MEM_LAT+1.
REQ-030 if_rdata updates only on fetch completion; d_rdata only on LDR completion. Both hold value otherwise; STR leaves d_rdata unchanged.
REQ-031 Requester SHALL hold req and operands stable until its ack. Dropping req at ack allows back-to-back grants from the next IDLE cycle.
REQ-032 Outside ACCESS: mem_en=0, mem_rw=1; no write strobe is ever issued outside ACCESS.
REQ-033 Requests arriving during ACCESS/DONE are not sampled until IDLE.

Reset
REQ-034 rst high at an edge SHALL force state IDLE, starve count 0 and latency counter 0.
REQ-035 Reset values: mem_en 0, mem_rw 1, mem_addr 0, mem_wdata 0, if_ack 0, d_ack 0, d_err 0, if_rdata 0, d_rdata 0.
REQ-036 Reset mid-ACCESS SHALL abandon the access with no ack; mem_en is 0 in the cycle after the reset edge.

Structure
REQ-037 Package mem_arb_pkg SHALL hold OP_LDR=4'b1101, OP_STR=4'b1110, RW_READ=1, RW_WRITE=0 and the FSM state enum.
REQ-038 Grant selection (REQ-023/024 combinational pick) SHALL be sub-module mem_arb_select. FSM and datapath stay in mem_bus_arbiter.

Verification
REQ-039 MEM_LAT=2, if_req with if_addr=8'h3C, mem_rdata=32'hDEADBEEF -> mem_addr=16'h003C, mem_rw=1, mem_en high 2 cycles, if_ack at cycle 3, if_rdata=32'hDEADBEEF.
REQ-040 STR d_addr=16'h1234, d_wdata=32'hA5A5A5A5 -> mem_rw=0 for 2 cycles with constant addr/data; d_ack once; d_rdata unchanged.
REQ-041 if_req and d_req both held continuously, STARVE_MAX=3 -> grant order D,D,D,F,D,D,D,F; no fetch waits more than 3 data grants.
REQ-042 d_req with d_op=4'b0011 -> mem_en never asserted; d_ack=1, d_err=1 one cycle after grant.
REQ-043 rst asserted in the 1st ACCESS cycle of an LDR -> no d_ack; all outputs at reset values next cycle; a new fetch then completes normally.
REQ-044 MEM_LAT=1, back-to-back LDRs with req dropped at ack -> mem_en high 1 cycle each, d_ack every 3 cycles.
